// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets,
// register-select decode and the byte-enable merge helper.
package clint_pkg;

    // Byte offsets within the 64 KiB CLINT window
    localparam logic [15:0] MSIP_OFS        = 16'h0000;
    localparam logic [15:0] MTIMECMP_LO_OFS = 16'h4000;
    localparam logic [15:0] MTIMECMP_HI_OFS = 16'h4004;
    localparam logic [15:0] MTIME_LO_OFS    = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFS    = 16'hBFFC;

    // Which architectural register a bus access targets
    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI
    } reg_sel_e;

    // Map a word-aligned offset to its register; unmapped offsets give REG_NONE
    function automatic reg_sel_e decode_reg(input logic [15:0] ofs);
        reg_sel_e sel;
        case (ofs)
            MSIP_OFS:        sel = REG_MSIP;
            MTIMECMP_LO_OFS: sel = REG_CMP_LO;
            MTIMECMP_HI_OFS: sel = REG_CMP_HI;
            MTIME_LO_OFS:    sel = REG_TIME_LO;
            MTIME_HI_OFS:    sel = REG_TIME_HI;
            default:         sel = REG_NONE;
        endcase
        return sel;
    endfunction

    // Replace only the bytes enabled in sel; sel[n] covers bits [8n+7:8n]
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old,
        input logic [31:0] data,
        input logic [3:0]  sel
    );
        logic [31:0] mask;
        for (int n = 0; n < 4; n++) begin
            mask[8*n +: 8] = {8{sel[n]}};
        end
        return (old & ~mask) | (data & mask);
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Divides the core clock down to the mtime tick rate. tick_o is high for
// one cycle out of every TICK_DIV; with TICK_DIV = 1 it is always high.
module clint_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk_i,
    input  logic reset_n_i,
    output logic tick_o
);

    localparam logic [15:0] LAST_CNT = 16'(TICK_DIV - 1);

    logic [15:0] r_div_cnt;

    // The tick is decoded combinationally so mtime advances on the same edge
    // on which the counter wraps.
    assign tick_o = (r_div_cnt == LAST_CNT);

    // Count 0..TICK_DIV-1 and wrap on the tick
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_div_cnt <= 16'd0;
        end else if (tick_o) begin
            r_div_cnt <= 16'd0;
        end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// RISC-V core-local interruptor: msip, 64-bit mtime and mtimecmp on a
// single-cycle-ack Wishbone-style slave port. The address decoder outside
// this block qualifies stb_i; only adr_i[15:2] is looked at here.
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        timer_interrupt_o,
    output logic        software_interrupt_o
);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic w_tick;

    clint_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .tick_o    (w_tick)
    );

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [15:0] w_ofs;
    reg_sel_e    w_reg;
    logic        w_wr;
    logic        w_wr_msip;
    logic        w_wr_cmp_lo;
    logic        w_wr_cmp_hi;
    logic        w_wr_time_lo;
    logic        w_wr_time_hi;
    logic        w_wr_time;
    logic        w_unused;

    // Byte-lane bits and everything above the 64 KiB window are not decoded
    assign w_unused     = ^{adr_i[31:16], adr_i[1:0]};

    assign w_ofs        = {adr_i[15:2], 2'b00};
    assign w_reg        = decode_reg(w_ofs);
    assign w_wr         = stb_i & we_i;
    assign w_wr_msip    = w_wr && (w_reg == REG_MSIP);
    assign w_wr_cmp_lo  = w_wr && (w_reg == REG_CMP_LO);
    assign w_wr_cmp_hi  = w_wr && (w_reg == REG_CMP_HI);
    assign w_wr_time_lo = w_wr && (w_reg == REG_TIME_LO);
    assign w_wr_time_hi = w_wr && (w_reg == REG_TIME_HI);
    // A write to either mtime word suppresses the tick for the whole 64 bits
    assign w_wr_time    = w_wr_time_lo | w_wr_time_hi;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic        r_msip;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_ack;
    logic [31:0] r_data;
    logic        r_tint;
    logic [31:0] w_rd_data;

    // msip: only bit 0 exists, enabled by the lowest byte lane
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_msip <= 1'b0;
        end else if (w_wr_msip && sel_i[0]) begin
            r_msip <= data_i[0];
        end
    end

    // mtimecmp: independent byte-masked updates of each 32-bit half
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else begin
            if (w_wr_cmp_lo) begin
                r_mtimecmp[31:0] <= byte_merge(r_mtimecmp[31:0], data_i, sel_i);
            end
            if (w_wr_cmp_hi) begin
                r_mtimecmp[63:32] <= byte_merge(r_mtimecmp[63:32], data_i, sel_i);
            end
        end
    end

    // mtime: bus writes win over the tick; unselected bytes keep their old
    // value rather than the incremented one, so the written word is exact.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mtime <= 64'd0;
        end else if (w_wr_time) begin
            if (w_wr_time_lo) begin
                r_mtime[31:0] <= byte_merge(r_mtime[31:0], data_i, sel_i);
            end
            if (w_wr_time_hi) begin
                r_mtime[63:32] <= byte_merge(r_mtime[63:32], data_i, sel_i);
            end
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // Read path and handshake
    // ------------------------------------------------------------------

    // Read mux over pre-update register values
    always_comb begin
        w_rd_data = 32'd0;
        case (w_reg)
            REG_MSIP:    w_rd_data = {31'd0, r_msip};
            REG_CMP_LO:  w_rd_data = r_mtimecmp[31:0];
            REG_CMP_HI:  w_rd_data = r_mtimecmp[63:32];
            REG_TIME_LO: w_rd_data = r_mtime[31:0];
            REG_TIME_HI: w_rd_data = r_mtime[63:32];
            default:     w_rd_data = 32'd0;
        endcase
    end

    // One ack per sampled strobe cycle; read data is captured only on strobe
    // so it stays stable while the bus is idle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ack  <= 1'b0;
            r_data <= 32'd0;
        end else begin
            r_ack <= stb_i;
            if (stb_i) begin
                r_data <= w_rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupts
    // ------------------------------------------------------------------

    // Registered unsigned compare of the current register contents; this adds
    // exactly one cycle between the state change and the interrupt edge.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_tint <= 1'b0;
        end else begin
            r_tint <= (r_mtime >= r_mtimecmp);
        end
    end

    assign data_o               = r_data;
    assign ack_o                = r_ack;
    assign timer_interrupt_o    = r_tint;
    assign software_interrupt_o = r_msip;

endmodule
